mem_stage_pipe: RTL and testbench
=================================

// Module: mem_stage_pipe
// PURPOSE
//  Next-generation MEM pipeline stage for the 5-stage core: EX/MEM in, MEM/WB out.
//  - Holds a parametrised byte-enabled data RAM; supports byte/half/word access with sign/zero extension.
//  - Supports a configurable load wait-state count, stalling the upstream stage through a ready handshake.
//  - Resolves branches (pc_src) and registers write-back control, destination register, ALU result and load data.
// PARAMETERS
//  DEPTH     1024  data RAM depth in 32-bit words (power of 2); AW = $clog2(DEPTH)
//  READ_LAT  0     extra wait cycles per load (0..15); stores always take 1 cycle
//  REG_W     5     destination register index width
//  WB_W      2     write-back control width; bit1 = reg_write, bit0 = mem_to_reg
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      synchronous, active-high reset
//  in_valid      in   1      EX/MEM holds a valid instruction
//  in_ready      out  1      stage accepts this cycle; transfer = in_valid & in_ready
//  branch        in   1      instruction is a conditional branch
//  zero          in   1      ALU zero flag
//  mem_write     in   1      store
//  mem_read      in   1      load (mem_write takes priority if both are set)
//  size          in   2      00 byte, 01 half, 10 word, 11 = treated as word
//  sign_ext      in   1      loads: 1 = sign-extend, 0 = zero-extend
//  wb_ctrl       in   WB_W   write-back control, passed through
//  dest_reg      in   REG_W  destination register index
//  alu_result    in   32     ALU result / byte address
//  write_data    in   32     store data (low bytes used for byte/half)
//  pc_src        out  1      branch taken (combinational)
//  out_valid     out  1      MEM/WB register holds a completed instruction (1-cycle pulse)
//  reg_write     out  1      registered wb_ctrl[1]
//  mem_to_reg    out  1      registered wb_ctrl[0]
//  dest_reg_out  out  REG_W  registered dest_reg
//  read_data     out  32     extended load data; 0 for non-loads
//  alu_out       out  32     registered alu_result
//  misalign      out  1      misaligned-access flag (only with MEM_ALIGN_CHECK_EN; tied 0 otherwise)
// BEHAVIOUR
//  - Reset: all registered outputs = 0, FSM = IDLE, wait counter = 0. RAM contents are not cleared.
//  - pc_src = in_valid & in_ready & branch & zero. It asserts once per branch, never during a stall.
//  - Addressing: word index = alu_result[AW+1:2]; upper bits are ignored (wraps modulo DEPTH).
//    Byte lane = alu_result[1:0], little-endian.
//  - Store: on transfer, write the enabled lanes at the clock edge (byte: 1 lane; half: lanes {a1,0}+1..0; word: all 4).
//    Next cycle: out_valid = 1, read_data = 0. No stall.
//  - Load: the RAM read is combinational from the index. Data is shifted by lane and extended per size/sign_ext.
//  - FSM IDLE/WAIT:
//    - IDLE: in_ready = 1.
//    - Load transfer with READ_LAT = 0: result registered at the same edge; out_valid next cycle.
//    - Load transfer with READ_LAT > 0: enter WAIT, counter = READ_LAT, latch address/size/sign/ctrl.
//    - WAIT: in_ready = 0; counter decrements each cycle. At counter == 1, register the result and go to IDLE.
//    - Net effect: out_valid rises READ_LAT+1 cycles after the transfer edge.
//  - Non-memory op (neither read nor write): pass-through in 1 cycle; read_data = 0.
//  - No transfer in a cycle: out_valid = 0 next cycle; other outputs hold their previous values.
//  - Reset mid-WAIT aborts the load: no out_valid, no RAM change, FSM = IDLE.
//  - Store followed back-to-back by a load to the same word: the load returns the new data (write lands first).
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined:
//    - Half with a[0] = 1, or word with a[1:0] != 0, sets misalign = 1 alongside out_valid.
//    - Such a store writes nothing. Such a load returns read_data = 0 and forces reg_write = 0.
//  MEM_ALIGN_CHECK_EN undefined:
//    - Misaligned low bits are ignored: half uses a[1] only, word uses lane 0. misalign is tied to 0.
// STRUCTURE
//  Package mem_stage_pkg:
//    - size_e {SZ_B, SZ_H, SZ_W}; state_e {S_IDLE, S_WAIT}.
//    - WB_REG_WRITE / WB_MEM_TO_REG bit indices.
//    - Byte-enable and extend functions.
//  Sub-module dmem_byte_ram: DEPTH x 32 array, 4 byte enables, synchronous write, asynchronous read.
//  The top level holds the FSM, lane logic and MEM/WB register.
// TESTING
//  - Reset held 2 cycles -> all outputs 0, in_ready = 1, pc_src = 0.
//  - Store word 0xABCDEF12 @0, then load word @0 to dest 1 (READ_LAT = 0)
//    -> out_valid the next cycle, read_data = 0xABCDEF12, dest_reg_out = 1.
//  - Load byte @3 signed -> 0xFFFFFFAB; unsigned -> 0x000000AB; half @2 signed -> 0xFFFFABCD;
//    store byte 0x55 @1, then load word -> 0xABCD5512.
//  - READ_LAT = 2 load: in_ready low 2 cycles, out_valid 3 cycles after transfer, no second transfer accepted.
//    Reset asserted in WAIT -> no out_valid.
//  - branch = 1, zero = 1 -> pc_src = 1 in the same cycle; zero = 0 -> pc_src = 0; during WAIT -> pc_src = 0.
//  - Half store @1: with MEM_ALIGN_CHECK_EN -> misalign = 1, RAM unchanged; without it -> writes lanes 1..0.
//    Address DEPTH*4 aliases word 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and lane helpers for the MEM pipeline stage.
// Pure combinational functions, no latency; no flow control of their own.
// Size encoding 2'b11 is deliberately folded into the word cases.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;

    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            SZ_B:    byte_en = 4'b0001 << lane;
            SZ_H:    byte_en = lane[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    // Replicate the low bytes so the RAM can pick them up on any enabled lane.
    function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            SZ_B:    store_lanes = {4{wd[7:0]}};
            SZ_H:    store_lanes = {2{wd[15:0]}};
            default: store_lanes = wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [1:0] lane, input logic sgn);
        logic [31:0] sh;
        logic [15:0] half;
        sh   = word >> {lane, 3'b000};
        half = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_B:    load_extend = {{24{sgn & sh[7]}}, sh[7:0]};
            SZ_H:    load_extend = {{16{sgn & half[15]}}, half};
            default: load_extend = word;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lane);
        case (sz)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = lane[0];
            default: misaligned = (lane != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_pipe_dmem.sv
// Byte-enabled DEPTH x 32 data RAM: synchronous write, asynchronous read.
// Read is combinational (0 cycles); write lands on the next rising edge.
// No backpressure; the caller gates i_we.
module dmem_byte_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM stage: data RAM access, branch resolve, MEM/WB register (MEM_ALIGN_CHECK_EN adds misalign trap).
// Latency: 1 cycle for stores/ALU ops, READ_LAT+1 cycles for loads.
// Backpressure: in_ready drops while a load sits in its wait states.
module mem_stage_pipe
    import mem_stage_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 0,
    parameter int REG_W    = 5,
    parameter int WB_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             branch,
    input  logic             zero,
    input  logic             mem_write,
    input  logic             mem_read,
    input  logic [1:0]       size,
    input  logic             sign_ext,
    input  logic [WB_W-1:0]  wb_ctrl,
    input  logic [REG_W-1:0] dest_reg,
    input  logic [31:0]      alu_result,
    input  logic [31:0]      write_data,
    output logic             pc_src,
    output logic             out_valid,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic [REG_W-1:0] dest_reg_out,
    output logic [31:0]      read_data,
    output logic [31:0]      alu_out,
    output logic             misalign
);

    localparam int         AW  = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(READ_LAT);

    state_e           r_state, w_state_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic [1:0]       r_size;
    logic             r_sign;
    logic [WB_W-1:0]  r_wb;
    logic [REG_W-1:0] r_dest;
    logic [31:0]      r_alu;

    logic             r_out_valid, r_reg_write, r_mem_to_reg, r_mis;
    logic [REG_W-1:0] r_dest_out;
    logic [31:0]      r_rdata, r_alu_out;

    logic             w_xfer, w_in_wait, w_is_load, w_is_store;
    logic             w_eff_load, w_eff_store, w_mis, w_we, w_cap;
    logic             w_start_wait, w_wait_done;
    logic [1:0]       w_size, w_lane;
    logic             w_sign;
    logic [WB_W-1:0]  w_wb;
    logic [REG_W-1:0] w_dest;
    logic [31:0]      w_alu, w_rdata, w_ld_data;
    logic [3:0]       w_be;

    assign in_ready   = (r_state == S_IDLE);
    assign w_xfer     = in_valid & in_ready;
    assign pc_src     = w_xfer & branch & zero;
    assign w_in_wait  = (r_state == S_WAIT);
    assign w_is_store = mem_write;
    assign w_is_load  = mem_read & ~mem_write;

    // While waiting, every lane/extension decision comes from the latched load.
    assign w_size      = w_in_wait ? r_size : size;
    assign w_sign      = w_in_wait ? r_sign : sign_ext;
    assign w_wb        = w_in_wait ? r_wb   : wb_ctrl;
    assign w_dest      = w_in_wait ? r_dest : dest_reg;
    assign w_alu       = w_in_wait ? r_alu  : alu_result;
    assign w_eff_load  = w_in_wait | w_is_load;
    assign w_eff_store = ~w_in_wait & w_is_store;
    assign w_lane      = w_alu[1:0];

`ifdef MEM_ALIGN_CHECK_EN
    assign w_mis = (w_eff_load | w_eff_store) & misaligned(w_size, w_lane);
`else
    assign w_mis = 1'b0;
`endif

    assign w_we      = w_xfer & w_eff_store & ~w_mis;
    assign w_be      = byte_en(w_size, w_lane);
    assign w_ld_data = (w_eff_load & ~w_mis) ? load_extend(w_rdata, w_size, w_lane, w_sign) : 32'd0;

    dmem_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (w_alu[AW+1:2]),
        .i_wdata (store_lanes(w_size, write_data)),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_start_wait = 1'b0;
        w_wait_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_xfer && w_is_load && (LAT != 4'd0)) begin
                    w_state_nxt  = S_WAIT;
                    w_cnt_nxt    = LAT;
                    w_start_wait = 1'b1;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_IDLE;
                    w_wait_done = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_cap = (w_xfer & ~w_start_wait) | w_wait_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_size <= 2'd0;
            r_sign <= 1'b0;
            r_wb   <= '0;
            r_dest <= '0;
            r_alu  <= 32'd0;
        end else if (w_start_wait) begin
            r_size <= size;
            r_sign <= sign_ext;
            r_wb   <= wb_ctrl;
            r_dest <= dest_reg;
            r_alu  <= alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_dest_out   <= '0;
            r_rdata      <= 32'd0;
            r_alu_out    <= 32'd0;
            r_mis        <= 1'b0;
        end else begin
            r_out_valid <= w_cap;
            if (w_cap) begin
                r_reg_write  <= w_wb[WB_REG_WRITE] & ~(w_eff_load & w_mis);
                r_mem_to_reg <= w_wb[WB_MEM_TO_REG];
                r_dest_out   <= w_dest;
                r_rdata      <= w_ld_data;
                r_alu_out    <= w_alu;
                r_mis        <= w_mis;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign reg_write    = r_reg_write;
    assign mem_to_reg   = r_mem_to_reg;
    assign dest_reg_out = r_dest_out;
    assign read_data    = r_rdata;
    assign alu_out      = r_alu_out;
    assign misalign     = r_mis;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: instance A (READ_LAT=0) against a byte-array model, instance B (READ_LAT=2) directed.
module tb_mem_stage_pipe;
    import mem_stage_pkg::*;

    localparam int DEPTH = 1024;
    localparam logic [31:0] MASK = 32'(DEPTH*4 - 1);
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, branch, zero, mem_write, mem_read, sign_ext;
    logic [1:0]  size, wb_ctrl;
    logic [4:0]  dest_reg;
    logic [31:0] alu_result, write_data;

    logic        a_valid, a_in_ready, a_pc_src, a_out_valid, a_reg_write, a_mem_to_reg, a_misalign;
    logic [4:0]  a_dest;
    logic [31:0] a_read_data, a_alu_out;
    logic        b_valid, b_in_ready, b_pc_src, b_out_valid, b_reg_write, b_mem_to_reg, b_misalign;
    logic [4:0]  b_dest;
    logic [31:0] b_read_data, b_alu_out;

    mem_stage_pipe #(.DEPTH(DEPTH), .READ_LAT(0)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_in_ready),
        .branch(branch), .zero(zero), .mem_write(mem_write), .mem_read(mem_read),
        .size(size), .sign_ext(sign_ext), .wb_ctrl(wb_ctrl), .dest_reg(dest_reg),
        .alu_result(alu_result), .write_data(write_data), .pc_src(a_pc_src),
        .out_valid(a_out_valid), .reg_write(a_reg_write), .mem_to_reg(a_mem_to_reg),
        .dest_reg_out(a_dest), .read_data(a_read_data), .alu_out(a_alu_out), .misalign(a_misalign)
    );

    mem_stage_pipe #(.DEPTH(DEPTH), .READ_LAT(2)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_in_ready),
        .branch(branch), .zero(zero), .mem_write(mem_write), .mem_read(mem_read),
        .size(size), .sign_ext(sign_ext), .wb_ctrl(wb_ctrl), .dest_reg(dest_reg),
        .alu_result(alu_result), .write_data(write_data), .pc_src(b_pc_src),
        .out_valid(b_out_valid), .reg_write(b_reg_write), .mem_to_reg(b_mem_to_reg),
        .dest_reg_out(b_dest), .read_data(b_read_data), .alu_out(b_alu_out), .misalign(b_misalign)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] mem_a [DEPTH*4];
    logic        p_rw, p_m2r, p_mis;
    logic [4:0]  p_dst;
    logic [31:0] p_rd, p_alu;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] addr, input logic [1:0] sz, input logic sgn);
        int b;
        logic [31:0] v;
        b = int'(addr & MASK);
        if (sz == 2'd0) begin
            v = {24'h0, mem_a[b]};
            if (sgn && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            b = b & ~1;
            v = {16'h0, mem_a[b+1], mem_a[b]};
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            b = b & ~3;
            v = {mem_a[b+3], mem_a[b+2], mem_a[b+1], mem_a[b]};
        end
        return v;
    endfunction

    task automatic m_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd);
        int b;
        int n;
        b = int'(addr & MASK);
        if (sz == 2'd0) n = 1;
        else if (sz == 2'd1) begin n = 2; b = b & ~1; end
        else begin n = 4; b = b & ~3; end
        for (int i = 0; i < n; i++) mem_a[b+i] = wd[8*i +: 8];
    endtask

    task automatic set_in(input logic mw, input logic mr, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] dst,
                          input logic [1:0] wb, input logic br, input logic zr);
        mem_write = mw; mem_read = mr; size = sz; sign_ext = sgn;
        alu_result = addr; write_data = wd; dest_reg = dst; wb_ctrl = wb;
        branch = br; zero = zr;
    endtask

    // One cycle on instance A, called at a falling edge; returns at the next falling edge.
    task automatic a_step(input logic v, input logic mw, input logic mr, input logic [1:0] sz,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] dst, input logic [1:0] wb, input logic br, input logic zr);
        logic ld, st, mis;
        set_in(mw, mr, sz, sgn, addr, wd, dst, wb, br, zr);
        a_valid = v;
        b_valid = 1'b0;
        #1;
        chk("a_pc_src", 32'(a_pc_src), 32'(v & br & zr));
        chk("a_in_ready", 32'(a_in_ready), 32'd1);
        st  = mw;
        ld  = mr & ~mw;
        mis = ALIGN && (ld || st) && ((sz == 2'd1 && addr[0]) || (sz[1] && addr[1:0] != 2'b00));
        if (v) begin
            p_rd = 32'd0;
            if (ld && !mis) p_rd = m_load(addr, sz, sgn);
            if (st && !mis) m_store(addr, sz, wd);
            p_rw  = wb[1] & ~(ld & mis);
            p_m2r = wb[0];
            p_dst = dst;
            p_alu = addr;
            p_mis = mis;
        end
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        chk("a_out_valid", 32'(a_out_valid), 32'(v));
        chk("a_reg_write", 32'(a_reg_write), 32'(p_rw));
        chk("a_mem_to_reg", 32'(a_mem_to_reg), 32'(p_m2r));
        chk("a_dest", 32'(a_dest), 32'(p_dst));
        chk("a_read_data", a_read_data, p_rd);
        chk("a_alu_out", a_alu_out, p_alu);
        chk("a_misalign", 32'(a_misalign), 32'(p_mis));
    endtask

    task automatic a_clear_prev();
        p_rw = 1'b0; p_m2r = 1'b0; p_mis = 1'b0; p_dst = 5'd0; p_rd = 32'd0; p_alu = 32'd0;
    endtask

    task automatic b_store(input logic [31:0] addr, input logic [31:0] wd);
        set_in(1'b1, 1'b0, 2'd2, 1'b0, addr, wd, 5'd0, 2'b00, 1'b0, 1'b0);
        b_valid = 1'b1;
        a_valid = 1'b0;
        #1 chk("b_st_ready", 32'(b_in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        chk("b_st_valid", 32'(b_out_valid), 32'd1);
        chk("b_st_rdata", b_read_data, 32'd0);
    endtask

    task automatic b_load(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                          input logic sgn, input logic [4:0] dst, input logic [31:0] exp);
        int lat;
        int low;
        set_in(1'b0, 1'b1, sz, sgn, addr, 32'd0, dst, 2'b11, 1'b0, 1'b0);
        b_valid = 1'b1;
        a_valid = 1'b0;
        #1 chk({tag, "_rdy0"}, 32'(b_in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        lat = 0;
        low = 0;
        for (int c = 1; c <= 10; c++) begin
            if (!b_in_ready) low++;
            if (b_out_valid) begin
                lat = c;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk({tag, "_lat"}, 32'(lat), 32'd3);
        chk({tag, "_stall"}, 32'(low), 32'd2);
        chk({tag, "_data"}, b_read_data, exp);
        chk({tag, "_dest"}, 32'(b_dest), 32'(dst));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        rst = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        set_in(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        a_clear_prev();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_valid", 32'(a_out_valid), 32'd0);
        chk("rst_a_rw", 32'(a_reg_write), 32'd0);
        chk("rst_a_rdata", a_read_data, 32'd0);
        chk("rst_a_alu", a_alu_out, 32'd0);
        chk("rst_a_dest", 32'(a_dest), 32'd0);
        chk("rst_a_ready", 32'(a_in_ready), 32'd1);
        chk("rst_a_pc", 32'(a_pc_src), 32'd0);
        chk("rst_b_valid", 32'(b_out_valid), 32'd0);
        chk("rst_b_ready", 32'(b_in_ready), 32'd1);
        chk("rst_b_mis", 32'(b_misalign), 32'd0);
        rst = 1'b0;

        // Directed sequence on the zero-wait instance.
        a_step(1, 1, 0, 2'd2, 0, 32'd0, 32'hABCDEF12, 5'd0, 2'b00, 0, 0);
        a_step(1, 0, 1, 2'd2, 0, 32'd0, 32'd0, 5'd1, 2'b11, 0, 0);
        chk("ld_w0", a_read_data, 32'hABCDEF12);
        chk("ld_w0_dest", 32'(a_dest), 32'd1);
        a_step(1, 0, 1, 2'd0, 1, 32'd3, 32'd0, 5'd2, 2'b11, 0, 0);
        chk("ld_b3_s", a_read_data, 32'hFFFFFFAB);
        a_step(1, 0, 1, 2'd0, 0, 32'd3, 32'd0, 5'd2, 2'b11, 0, 0);
        chk("ld_b3_u", a_read_data, 32'h000000AB);
        a_step(1, 0, 1, 2'd1, 1, 32'd2, 32'd0, 5'd2, 2'b11, 0, 0);
        chk("ld_h2_s", a_read_data, 32'hFFFFABCD);
        a_step(1, 1, 0, 2'd0, 0, 32'd1, 32'h00000055, 5'd0, 2'b00, 0, 0);
        a_step(1, 0, 1, 2'd2, 0, 32'd0, 32'd0, 5'd4, 2'b11, 0, 0);
        chk("ld_w0_b55", a_read_data, 32'hABCD5512);
        a_step(1, 0, 0, 2'd0, 0, 32'h40, 32'd0, 5'd0, 2'b00, 1, 1);
        a_step(1, 0, 0, 2'd0, 0, 32'h44, 32'd0, 5'd0, 2'b00, 1, 0);
        a_step(1, 1, 0, 2'd1, 0, 32'd1, 32'h00007766, 5'd0, 2'b00, 0, 0);
        a_step(1, 0, 1, 2'd2, 0, 32'd0, 32'd0, 5'd5, 2'b11, 0, 0);
        chk("ld_after_h1", a_read_data, ALIGN ? 32'hABCD5512 : 32'hABCD7766);
        a_step(1, 0, 1, 2'd2, 0, 32'(DEPTH*4), 32'd0, 5'd6, 2'b11, 0, 0);
        chk("alias_w0", a_read_data, ALIGN ? 32'hABCD5512 : 32'hABCD7766);
        a_step(1, 0, 1, 2'd2, 0, 32'd2, 32'd0, 5'd7, 2'b11, 0, 0);

        // Waited-load instance.
        b_store(32'd8, 32'h11223344);
        b_store(32'd16, 32'hCAFEF00D);
        set_in(1'b0, 1'b1, 2'd2, 1'b0, 32'd8, 32'd0, 5'd3, 2'b11, 1'b0, 1'b0);
        b_valid = 1'b1;
        #1 chk("bw_rdy0", 32'(b_in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("bw_rdy1", 32'(b_in_ready), 32'd0);
        chk("bw_ov1", 32'(b_out_valid), 32'd0);
        set_in(1'b1, 1'b0, 2'd2, 1'b0, 32'd16, 32'hDEADBEEF, 5'd9, 2'b10, 1'b1, 1'b1);
        #1 chk("bw_pc1", 32'(b_pc_src), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("bw_rdy2", 32'(b_in_ready), 32'd0);
        chk("bw_ov2", 32'(b_out_valid), 32'd0);
        chk("bw_pc2", 32'(b_pc_src), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("bw_ov3", 32'(b_out_valid), 32'd1);
        chk("bw_rd3", b_read_data, 32'h11223344);
        chk("bw_dest3", 32'(b_dest), 32'd3);
        chk("bw_rw3", 32'(b_reg_write), 32'd1);
        chk("bw_rdy3", 32'(b_in_ready), 32'd1);
        b_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("bw_ov4", 32'(b_out_valid), 32'd0);
        chk("bw_hold4", b_read_data, 32'h11223344);
        b_load("b_w16", 32'd16, 2'd2, 1'b0, 5'd10, 32'hCAFEF00D);
        b_load("b_b11", 32'd11, 2'd0, 1'b1, 5'd11, 32'h00000011);
        b_load("b_h10", 32'd10, 2'd1, 1'b1, 5'd12, 32'h00001122);

        // Reset while the load is waiting must discard it.
        set_in(1'b0, 1'b1, 2'd2, 1'b0, 32'd8, 32'd0, 5'd13, 2'b11, 1'b0, 1'b0);
        b_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rstw_ready", 32'(b_in_ready), 32'd1);
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (b_out_valid) cnt++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("rstw_no_valid", 32'(cnt), 32'd0);
        chk("rstw_rdata", b_read_data, 32'd0);
        b_load("b_after_rst", 32'd8, 2'd2, 1'b0, 5'd14, 32'h11223344);
        a_clear_prev();

        // Randomised traffic on words 0..15 with random upper address bits.
        for (int w = 0; w < 16; w++) begin
            a_step(1, 1, 0, 2'd2, 0, 32'(w*4), $urandom, 5'd0, 2'b00, 0, 0);
        end
        for (int i = 0; i < 250; i++) begin
            logic [31:0] addr;
            int k;
            addr = ($urandom & ~MASK) | 32'($urandom_range(0, 63));
            k = $urandom_range(0, 3);
            a_step(($urandom_range(0, 3) != 0), (k == 0 || k == 3), (k == 1 || k == 3),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), addr, $urandom,
                   5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
